issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Out-of-order issue buffer for the issue stage.
- Holds up to els_p dispatched micro-ops and tracks readiness of their two source operands via tag wakeup broadcasts.
- Each cycle it selects one ready entry through a priority_encoder and presents it to the execute stage with a valid/yumi handshake.
- Sits between the rename/dispatch stage (upstream) and functional-unit operand read (downstream).

Parameters:
- els_p, 8, number of queue entries; power of two, at least 2.
- data_width_p, 32, opaque payload width (opcode, immediates, destination tag).
- tag_width_p, 6, physical-register tag width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- flush_i  in  1  clears all entries at the next edge
- enq_v_i  in  1  dispatch has a micro-op
- enq_ready_o  out  1  at least one free entry exists
- enq_data_i  in  data_width_p  payload
- enq_src0_tag_i  in  tag_width_p  source 0 tag
- enq_src0_rdy_i  in  1  source 0 already available
- enq_src1_tag_i  in  tag_width_p  source 1 tag
- enq_src1_rdy_i  in  1  source 1 already available
- wakeup_v_i  in  1  a result tag is broadcast this cycle
- wakeup_tag_i  in  tag_width_p  broadcast tag
- issue_v_o  out  1  a ready entry is presented
- issue_data_o  out  data_width_p  payload of selected entry
- issue_yumi_i  in  1  execute consumes presented entry; legal only when issue_v_o=1
- count_o  out  $clog2(els_p+1)  occupied entries

Behaviour:
- Per-entry state: valid, data, src0_tag, src0_rdy, src1_tag, src1_rdy. All are registers.
- Reset (reset_n_i=0 at an edge): all valid bits cleared.
  - Outputs after reset: enq_ready_o=1, issue_v_o=0, issue_data_o=0, count_o=0.
  - Reset overrides every other input in that cycle.
- Enqueue:
  - Fires when enq_v_i & enq_ready_o.
  - Writes the lowest-index free entry, chosen by a priority_encoder on ~valid using the current-cycle state.
  - enq_ready_o = |(~valid); it depends only on registered state, never on issue_yumi_i.
  - Stored srcN_rdy = enq_srcN_rdy_i | (wakeup_v_i & wakeup_tag_i==enq_srcN_tag_i); same-cycle wakeup bypass is required.
- Wakeup:
  - When wakeup_v_i is high, every valid entry whose srcN_tag equals wakeup_tag_i sets srcN_rdy at the edge.
  - Both sources of one entry may wake in the same cycle.
  - Already-ready sources are unaffected.
- Select:
  - ready_vec = valid & src0_rdy & src1_rdy.
  - A priority_encoder on ready_vec picks the lowest index.
  - issue_v_o = |ready_vec.
  - issue_data_o = data of the selected entry when issue_v_o=1, else 0.
  - Select is combinational from registers: zero cycles from ready to presentation.
  - Wakeup-to-issue latency is one cycle; a same-cycle wakeup does not make an entry issuable that cycle.
- Issue handshake:
  - issue_yumi_i=1 clears the selected entry's valid at the edge.
  - Without yumi, the selection may change next cycle if a lower-index entry becomes ready. Consumers must not rely on a stable selection.
- Simultaneous enqueue and issue:
  - Both occur.
  - The slot freed by issue is not reusable in the same cycle; enqueue uses a slot free before the edge.
  - count_o is unchanged.
- Full: enq_ready_o=0; enq_v_i is ignored. Upstream holds its data.
- Empty: issue_v_o=0; issue_yumi_i must be 0 (assert in simulation).
- flush_i:
  - At the edge, all valid bits are cleared, and same-cycle enqueue and yumi are discarded.
  - Outputs in the flush cycle still reflect current state.
- count_o is registered; it is incremented on enqueue and decremented on yumi, and set to 0 on flush or reset.
- Selection is index-ordered, not age-ordered. Starvation freedom relies on downstream throughput and is out of scope.

Decomposition:
- Shared package issue_pkg:
  - Struct typedef iq_entry_s (valid, data, tags, rdy bits).
  - Tag width constant shared with rename and wakeup logic.
- Reuse the existing priority_encoder twice: free-slot select and ready select.
- One natural sub-module: iq_entry, holding one entry's storage and its wakeup comparators, instantiated els_p times.

Test Plan:
- Reset, then enqueue 8 ops with both srcs rdy=1 -> enq_ready_o drops after the 8th; issue_v_o=1 with entry 0 data; yumi for 8 cycles -> data order 0..7, count_o returns to 0.
- Enqueue op A with src0_tag=5 not ready, src1 ready; wakeup tag 5 two cycles later -> issue_v_o rises exactly one cycle after the wakeup cycle.
- Enqueue op with src0_tag=9 not ready while wakeup_v_i=1, tag=9 in the same cycle -> entry stored ready, issue_v_o=1 the next cycle.
- Queue full, assert enq_v_i and issue_yumi_i together -> enqueue ignored, issue happens, count_o=7, enq_ready_o=1 the next cycle.
- Entries 2 and 5 waiting on tag 3; wakeup tag 3 -> entry 2 issues first (lowest index); entry 5 issues the cycle after yumi.
- 4 entries valid, assert flush_i with enq_v_i=1 -> next cycle count_o=0, issue_v_o=0, enq_ready_o=1; deassert reset_n_i mid-operation -> same all-empty state.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared issue-stage types: tag/payload widths and the per-entry record
// used by the issue queue and the rename/wakeup logic.
package issue_pkg;

  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  src0_tag;
    logic              src0_rdy;
    logic [TAG_W-1:0]  src1_tag;
    logic              src1_rdy;
  } iq_entry_s;

  function automatic logic tag_hit(input logic             v,
                                   input logic [TAG_W-1:0] bcast,
                                   input logic [TAG_W-1:0] src);
    return v && (bcast == src);
  endfunction

endpackage

// File: rtl/iq_entry.sv
// One issue-queue slot: payload/tag storage plus wakeup comparators for both sources.
module iq_entry
  import issue_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic              deq_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TAG_W-1:0]  src0_tag_i,
  input  logic              src0_rdy_i,
  input  logic [TAG_W-1:0]  src1_tag_i,
  input  logic              src1_rdy_i,
  input  logic              wake_v_i,
  input  logic [TAG_W-1:0]  wake_tag_i,
  output iq_entry_s         entry_o
);

  iq_entry_s entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (clear_i) begin
      entry_d.valid = 1'b0;
    end else if (we_i) begin
      // A broadcast in the dispatch cycle must not be lost, so it is bypassed in.
      entry_d.valid    = 1'b1;
      entry_d.data     = data_i;
      entry_d.src0_tag = src0_tag_i;
      entry_d.src1_tag = src1_tag_i;
      entry_d.src0_rdy = src0_rdy_i | tag_hit(wake_v_i, wake_tag_i, src0_tag_i);
      entry_d.src1_rdy = src1_rdy_i | tag_hit(wake_v_i, wake_tag_i, src1_tag_i);
    end else if (entry_q.valid) begin
      if (tag_hit(wake_v_i, wake_tag_i, entry_q.src0_tag)) entry_d.src0_rdy = 1'b1;
      if (tag_hit(wake_v_i, wake_tag_i, entry_q.src1_tag)) entry_d.src1_rdy = 1'b1;
      if (deq_i) entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) entry_q <= '0;
    else            entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/priority_encoder.sv
// Lowest-index-first priority encoder with an any-set flag.
module priority_encoder #(
  parameter int unsigned width_p = 8
) (
  input  logic [width_p-1:0]         v_i,
  output logic [$clog2(width_p)-1:0] addr_o,
  output logic                       v_o
);

  always_comb begin
    addr_o = '0;
    // Walk from the top so the lowest set bit is the last one written.
    for (int i = width_p - 1; i >= 0; i--) begin
      if (v_i[i]) addr_o = ($clog2(width_p))'(i);
    end
    v_o = |v_i;
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue buffer: tag wakeup, lowest-index ready select,
// valid/yumi handshake towards execute.
module issue_queue
  import issue_pkg::*;
#(
  parameter int unsigned els_p        = 8,
  parameter int unsigned data_width_p = DATA_W,
  parameter int unsigned tag_width_p  = TAG_W
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       enq_v_i,
  output logic                       enq_ready_o,
  input  logic [data_width_p-1:0]    enq_data_i,
  input  logic [tag_width_p-1:0]     enq_src0_tag_i,
  input  logic                       enq_src0_rdy_i,
  input  logic [tag_width_p-1:0]     enq_src1_tag_i,
  input  logic                       enq_src1_rdy_i,
  input  logic                       wakeup_v_i,
  input  logic [tag_width_p-1:0]     wakeup_tag_i,
  output logic                       issue_v_o,
  output logic [data_width_p-1:0]    issue_data_o,
  input  logic                       issue_yumi_i,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int unsigned idx_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  iq_entry_s            entries [els_p];
  logic [els_p-1:0]     valid_vec, ready_vec;
  logic [idx_w_lp-1:0]  free_idx, sel_idx;
  logic                 free_v, enq_fire, issue_fire;
  logic [cnt_w_lp-1:0]  count_q, count_d;

  priority_encoder #(.width_p(els_p)) u_free_pe (
    .v_i    (~valid_vec),
    .addr_o (free_idx),
    .v_o    (free_v)
  );

  priority_encoder #(.width_p(els_p)) u_sel_pe (
    .v_i    (ready_vec),
    .addr_o (sel_idx),
    .v_o    (issue_v_o)
  );

  assign enq_ready_o = free_v;
  assign enq_fire    = enq_v_i & free_v;
  assign issue_fire  = issue_yumi_i & issue_v_o;

  for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
    iq_entry u_entry (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .clear_i    (flush_i),
      .we_i       (enq_fire && (free_idx == idx_w_lp'(gi))),
      .deq_i      (issue_fire && (sel_idx == idx_w_lp'(gi))),
      .data_i     (enq_data_i),
      .src0_tag_i (enq_src0_tag_i),
      .src0_rdy_i (enq_src0_rdy_i),
      .src1_tag_i (enq_src1_tag_i),
      .src1_rdy_i (enq_src1_rdy_i),
      .wake_v_i   (wakeup_v_i),
      .wake_tag_i (wakeup_tag_i),
      .entry_o    (entries[gi])
    );
    assign valid_vec[gi] = entries[gi].valid;
    assign ready_vec[gi] = entries[gi].valid & entries[gi].src0_rdy & entries[gi].src1_rdy;
  end

  assign issue_data_o = issue_v_o ? entries[sel_idx].data : '0;

  always_comb begin
    count_d = count_q + cnt_w_lp'(enq_fire) - cnt_w_lp'(issue_fire);
    if (flush_i) count_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

  assign count_o = count_q;

  a_no_yumi_when_empty: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) issue_yumi_i |-> issue_v_o
  );

endmodule

// File: tb/tb_issue_queue.sv
// Randomized and directed checks of issue_queue against a slot-level reference model.
module tb_issue_queue;

  logic        clk_i = 1'b0;
  logic        reset_n_i, flush_i, enq_v_i, enq_ready_o;
  logic [31:0] enq_data_i;
  logic [5:0]  enq_src0_tag_i, enq_src1_tag_i, wakeup_tag_i;
  logic        enq_src0_rdy_i, enq_src1_rdy_i, wakeup_v_i;
  logic        issue_v_o, issue_yumi_i;
  logic [31:0] issue_data_o;
  logic [3:0]  count_o;

  int compared = 0;
  int mismatched = 0;

  issue_queue dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .flush_i        (flush_i),
    .enq_v_i        (enq_v_i),
    .enq_ready_o    (enq_ready_o),
    .enq_data_i     (enq_data_i),
    .enq_src0_tag_i (enq_src0_tag_i),
    .enq_src0_rdy_i (enq_src0_rdy_i),
    .enq_src1_tag_i (enq_src1_tag_i),
    .enq_src1_rdy_i (enq_src1_rdy_i),
    .wakeup_v_i     (wakeup_v_i),
    .wakeup_tag_i   (wakeup_tag_i),
    .issue_v_o      (issue_v_o),
    .issue_data_o   (issue_data_o),
    .issue_yumi_i   (issue_yumi_i),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: one record per slot, in slot order.
  bit          m_valid [8];
  logic [31:0] m_data  [8];
  logic [5:0]  m_t0 [8], m_t1 [8];
  bit          m_r0 [8], m_r1 [8];

  function automatic bit exp_iv();
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_r0[i] && m_r1[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_data();
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_r0[i] && m_r1[i]) return m_data[i];
    return 32'h0;
  endfunction

  function automatic bit exp_ready();
    for (int i = 0; i < 8; i++) if (!m_valid[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m_valid[i] ? 1 : 0;
    return n;
  endfunction

  task automatic idle();
    flush_i = 0; enq_v_i = 0; enq_data_i = 0;
    enq_src0_tag_i = 0; enq_src0_rdy_i = 0; enq_src1_tag_i = 0; enq_src1_rdy_i = 0;
    wakeup_v_i = 0; wakeup_tag_i = 0; issue_yumi_i = 0;
  endtask

  task automatic set_enq(input logic [31:0] d, input logic [5:0] t0, input bit r0,
                         input logic [5:0] t1, input bit r1);
    enq_v_i = 1; enq_data_i = d;
    enq_src0_tag_i = t0; enq_src0_rdy_i = r0; enq_src1_tag_i = t1; enq_src1_rdy_i = r1;
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    int sel, fre;
    @(posedge clk_i);
    if (!reset_n_i || flush_i) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 0;
    end else begin
      sel = -1; fre = -1;
      for (int i = 7; i >= 0; i--) begin
        if (m_valid[i] && m_r0[i] && m_r1[i]) sel = i;
        if (!m_valid[i]) fre = i;
      end
      for (int i = 0; i < 8; i++) begin
        if (m_valid[i] && wakeup_v_i && m_t0[i] == wakeup_tag_i) m_r0[i] = 1;
        if (m_valid[i] && wakeup_v_i && m_t1[i] == wakeup_tag_i) m_r1[i] = 1;
      end
      if (issue_yumi_i && sel >= 0) m_valid[sel] = 0;
      if (enq_v_i && fre >= 0) begin
        m_valid[fre] = 1; m_data[fre] = enq_data_i;
        m_t0[fre] = enq_src0_tag_i; m_t1[fre] = enq_src1_tag_i;
        m_r0[fre] = enq_src0_rdy_i || (wakeup_v_i && wakeup_tag_i == enq_src0_tag_i);
        m_r1[fre] = enq_src1_rdy_i || (wakeup_v_i && wakeup_tag_i == enq_src1_tag_i);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); reset_n_i = 0;
    set_enq(32'hFFFF, 1, 1, 1, 1);
    tick(); tick();
    reset_n_i = 1; idle();
    compared++; if (enq_ready_o !== 1'b1) begin mismatched++; $display("FAIL reset_ready got=%b want=1", enq_ready_o); end
    compared++; if (issue_v_o !== 1'b0) begin mismatched++; $display("FAIL reset_issue_v got=%b want=0", issue_v_o); end
    compared++; if (issue_data_o !== 32'h0) begin mismatched++; $display("FAIL reset_data got=%h want=0", issue_data_o); end
    compared++; if (count_o !== 4'd0) begin mismatched++; $display("FAIL reset_count got=%0d want=0", count_o); end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      idle(); set_enq(32'h100 + i, 6'(i), 1, 6'(i + 1), 1);
      compared++; if (enq_ready_o !== 1'b1) begin mismatched++; $display("FAIL fill_ready[%0d] got=%b want=1", i, enq_ready_o); end
      tick();
      compared++; if (count_o !== 4'(i + 1)) begin mismatched++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count_o, i + 1); end
    end
    idle();
    compared++; if (enq_ready_o !== 1'b0) begin mismatched++; $display("FAIL full_ready got=%b want=0", enq_ready_o); end
    compared++; if (issue_v_o !== 1'b1) begin mismatched++; $display("FAIL full_issue_v got=%b want=1", issue_v_o); end
    for (int k = 0; k < 8; k++) begin
      issue_yumi_i = 1;
      compared++; if (issue_data_o !== 32'h100 + k) begin mismatched++; $display("FAIL drain_data[%0d] got=%h want=%h", k, issue_data_o, 32'h100 + k); end
      tick();
    end
    idle();
    compared++; if (count_o !== 4'd0) begin mismatched++; $display("FAIL drain_count got=%0d want=0", count_o); end
    compared++; if (issue_v_o !== 1'b0) begin mismatched++; $display("FAIL drain_issue_v got=%b want=0", issue_v_o); end
    $display("test_fill_drain done");
  endtask

  task automatic test_wakeup_latency();
    idle(); set_enq(32'hA0A0, 5, 0, 1, 1); tick();
    idle(); tick();
    compared++; if (issue_v_o !== 1'b0) begin mismatched++; $display("FAIL wait_issue_v got=%b want=0", issue_v_o); end
    wakeup_v_i = 1; wakeup_tag_i = 5;
    compared++; if (issue_v_o !== 1'b0) begin mismatched++; $display("FAIL wake_same_cycle got=%b want=0", issue_v_o); end
    tick(); idle();
    compared++; if (issue_v_o !== 1'b1) begin mismatched++; $display("FAIL wake_next_cycle got=%b want=1", issue_v_o); end
    compared++; if (issue_data_o !== 32'hA0A0) begin mismatched++; $display("FAIL wake_data got=%h want=a0a0", issue_data_o); end
    issue_yumi_i = 1; tick(); idle();
    compared++; if (count_o !== 4'd0) begin mismatched++; $display("FAIL wake_count got=%0d want=0", count_o); end
    $display("test_wakeup_latency done");
  endtask

  task automatic test_bypass();
    idle(); set_enq(32'hB9B9, 9, 0, 2, 1); wakeup_v_i = 1; wakeup_tag_i = 9;
    tick(); idle();
    compared++; if (issue_v_o !== 1'b1) begin mismatched++; $display("FAIL bypass_issue_v got=%b want=1", issue_v_o); end
    compared++; if (issue_data_o !== 32'hB9B9) begin mismatched++; $display("FAIL bypass_data got=%h want=b9b9", issue_data_o); end
    issue_yumi_i = 1; tick(); idle();
    $display("test_bypass done");
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 8; i++) begin idle(); set_enq(32'h200 + i, 0, 1, 0, 1); tick(); end
    idle(); set_enq(32'hDEAD, 0, 1, 0, 1); issue_yumi_i = 1;
    compared++; if (enq_ready_o !== 1'b0) begin mismatched++; $display("FAIL simul_full_ready got=%b want=0", enq_ready_o); end
    tick(); idle();
    compared++; if (count_o !== 4'd7) begin mismatched++; $display("FAIL simul_count got=%0d want=7", count_o); end
    compared++; if (enq_ready_o !== 1'b1) begin mismatched++; $display("FAIL simul_ready got=%b want=1", enq_ready_o); end
    compared++; if (issue_data_o !== 32'h201) begin mismatched++; $display("FAIL simul_next_data got=%h want=201", issue_data_o); end
    for (int k = 0; k < 7; k++) begin issue_yumi_i = 1; tick(); end
    idle();
    compared++; if (count_o !== 4'd0) begin mismatched++; $display("FAIL simul_drain_count got=%0d want=0", count_o); end
    $display("test_full_simul done");
  endtask

  task automatic test_order();
    for (int i = 0; i < 6; i++) begin
      idle(); set_enq(32'h300 + i, (i == 2 || i == 5) ? 6'd3 : 6'd20, 0, 0, 1); tick();
    end
    idle();
    compared++; if (issue_v_o !== 1'b0) begin mismatched++; $display("FAIL order_idle got=%b want=0", issue_v_o); end
    wakeup_v_i = 1; wakeup_tag_i = 3; tick(); idle();
    compared++; if (issue_data_o !== 32'h302) begin mismatched++; $display("FAIL order_first got=%h want=302", issue_data_o); end
    issue_yumi_i = 1; tick(); idle();
    compared++; if (issue_data_o !== 32'h305) begin mismatched++; $display("FAIL order_second got=%h want=305", issue_data_o); end
    issue_yumi_i = 1; tick(); idle();
    compared++; if (count_o !== 4'd4) begin mismatched++; $display("FAIL order_count got=%0d want=4", count_o); end
    $display("test_order done");
  endtask

  task automatic test_flush_reset();
    idle(); flush_i = 1; set_enq(32'hF00D, 0, 1, 0, 1);
    compared++; if (count_o !== 4'd4) begin mismatched++; $display("FAIL flush_cycle_count got=%0d want=4", count_o); end
    tick(); idle();
    compared++; if (count_o !== 4'd0) begin mismatched++; $display("FAIL flush_count got=%0d want=0", count_o); end
    compared++; if (issue_v_o !== 1'b0) begin mismatched++; $display("FAIL flush_issue_v got=%b want=0", issue_v_o); end
    compared++; if (enq_ready_o !== 1'b1) begin mismatched++; $display("FAIL flush_ready got=%b want=1", enq_ready_o); end
    for (int i = 0; i < 3; i++) begin idle(); set_enq(32'h400 + i, 0, 1, 0, 1); tick(); end
    idle(); reset_n_i = 0; set_enq(32'h4FF, 0, 1, 0, 1); tick();
    reset_n_i = 1; idle();
    compared++; if (count_o !== 4'd0) begin mismatched++; $display("FAIL rst_mid_count got=%0d want=0", count_o); end
    compared++; if (issue_v_o !== 1'b0) begin mismatched++; $display("FAIL rst_mid_issue_v got=%b want=0", issue_v_o); end
    compared++; if (enq_ready_o !== 1'b1) begin mismatched++; $display("FAIL rst_mid_ready got=%b want=1", enq_ready_o); end
    $display("test_flush_reset done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      reset_n_i = ($urandom_range(0, 79) != 0);
      flush_i = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1)
        set_enq($urandom, 6'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                6'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      wakeup_v_i = ($urandom_range(0, 1) == 1);
      wakeup_tag_i = 6'($urandom_range(0, 7));
      issue_yumi_i = exp_iv() && ($urandom_range(0, 2) != 0);
      compared++; if (issue_v_o !== exp_iv()) begin mismatched++; $display("FAIL rnd_issue_v[%0d] got=%b want=%b", c, issue_v_o, exp_iv()); end
      compared++; if (issue_data_o !== exp_data()) begin mismatched++; $display("FAIL rnd_data[%0d] got=%h want=%h", c, issue_data_o, exp_data()); end
      compared++; if (enq_ready_o !== exp_ready()) begin mismatched++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, enq_ready_o, exp_ready()); end
      compared++; if (count_o !== 4'(exp_count())) begin mismatched++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", c, count_o, exp_count()); end
      tick();
    end
    reset_n_i = 1; idle();
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wakeup_latency();
    test_bypass();
    test_full_simul();
    test_order();
    test_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
